// File: rtl/pipe_hazard_ctrl_pkg.sv
// Shared definitions for the pipeline hazard sequencer: state encoding,
// field widths and the instruction word that flushed pipe registers load.
package pipe_hazard_ctrl_pkg;

  // Sequencer states; the encoding is shared with debug/trace tooling.
  typedef enum logic [1:0] {
    ST_RUN    = 2'b00,
    ST_DWAIT  = 2'b01,
    ST_IWAIT  = 2'b10,
    ST_HALTED = 2'b11
  } state_e;

  localparam int REG_ADDR_W = 3;
  localparam int PC_W       = 16;

  // Instruction word loaded into FD/DX when they are flushed into a bubble.
  localparam logic [15:0] NOP_INSTR = 16'h0000;

endpackage

// File: rtl/pipe_hazard_ctrl_load_use_detect.sv
// Load-use hazard compare: the instruction in FD reads a register that the
// load currently in DX has not yet produced. r0 is an ordinary register here.
module pipe_hazard_ctrl_load_use_detect
  import pipe_hazard_ctrl_pkg::*;
(
  input  logic [REG_ADDR_W-1:0] fd_rs,
  input  logic [REG_ADDR_W-1:0] fd_rt,
  input  logic                  fd_uses_rs,
  input  logic                  fd_uses_rt,
  input  logic                  dx_memRead,
  input  logic                  dx_regWrite,
  input  logic [REG_ADDR_W-1:0] dx_writeReg,
  output logic                  hazard
);

  logic rs_match;
  logic rt_match;

  // Per-source match against the load's destination, then qualify by load.
  always_comb begin
    rs_match = fd_uses_rs && (fd_rs == dx_writeReg);
    rt_match = fd_uses_rt && (fd_rt == dx_writeReg);
    hazard   = dx_memRead && dx_regWrite && (rs_match || rt_match);
  end

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Central stall/flush sequencer for the five-stage pipeline. Produces the PC
// and pipe-register write enables plus FD/DX bubble inserts, and remembers a
// redirect that resolved while the fetch was stalled so it is not lost.
module pipe_hazard_ctrl
  import pipe_hazard_ctrl_pkg::*;
#(
  parameter int CNT_W = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [REG_ADDR_W-1:0] fd_rs,
  input  logic [REG_ADDR_W-1:0] fd_rt,
  input  logic                  fd_uses_rs,
  input  logic                  fd_uses_rt,
  input  logic                  dx_memRead,
  input  logic                  dx_regWrite,
  input  logic [REG_ADDR_W-1:0] dx_writeReg,
  input  logic                  x_redirect,
  input  logic [PC_W-1:0]       x_target,
  input  logic                  i_stall,
  input  logic                  d_stall,
  input  logic                  mw_halt,
  output logic                  pc_we,
  output logic                  pc_sel_redirect,
  output logic [PC_W-1:0]       redirect_pc,
  output logic                  fd_we,
  output logic                  dx_we,
  output logic                  xm_we,
  output logic                  mw_we,
  output logic                  fd_flush,
  output logic                  dx_flush,
  output logic                  halted,
  output logic [CNT_W-1:0]      stall_cnt
);

  state_e          state_q, state_d;
  logic            redir_pend_q, redir_pend_d;
  logic [PC_W-1:0] redir_pc_q, redir_pc_d;
  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
  logic            load_use;
  logic            redirect_active;

  pipe_hazard_ctrl_load_use_detect u_load_use (
    .fd_rs       (fd_rs),
    .fd_rt       (fd_rt),
    .fd_uses_rs  (fd_uses_rs),
    .fd_uses_rt  (fd_uses_rt),
    .dx_memRead  (dx_memRead),
    .dx_regWrite (dx_regWrite),
    .dx_writeReg (dx_writeReg),
    .hazard      (load_use)
  );

  // A live X-stage redirect or one held over from a stalled fetch.
  assign redirect_active = x_redirect || redir_pend_q;
  assign redirect_pc     = redir_pend_q ? redir_pc_q : x_target;
  assign halted          = (state_q == ST_HALTED);
  assign stall_cnt       = stall_cnt_q;

  // Priority decode: halt > data stall > redirect > load-use > fetch stall.
  always_comb begin
    state_d         = state_q;
    redir_pend_d    = redir_pend_q;
    redir_pc_d      = redir_pc_q;
    pc_we           = 1'b0;
    pc_sel_redirect = 1'b0;
    fd_we           = 1'b0;
    dx_we           = 1'b0;
    xm_we           = 1'b0;
    mw_we           = 1'b0;
    fd_flush        = 1'b0;
    dx_flush        = 1'b0;

    if (rst) begin
      state_d = ST_RUN;
    end else if (state_q == ST_HALTED) begin
      state_d = ST_HALTED;
    end else if (mw_halt) begin
      state_d = ST_HALTED;
    end else if (d_stall) begin
      // Whole pipe frozen; the X instruction will re-assert its redirect,
      // so capturing it now is harmless and saves nothing being lost.
      state_d = ST_DWAIT;
      if (x_redirect && !redir_pend_q) begin
        redir_pend_d = 1'b1;
        redir_pc_d   = x_target;
      end
    end else if (redirect_active) begin
      pc_sel_redirect = 1'b1;
      fd_we           = 1'b1;
      dx_we           = 1'b1;
      xm_we           = 1'b1;
      mw_we           = 1'b1;
      fd_flush        = 1'b1;
      dx_flush        = 1'b1;
      if (!i_stall) begin
        pc_we        = 1'b1;
        redir_pend_d = 1'b0;
        state_d      = ST_RUN;
      end else begin
        // Fetch cannot accept the new PC yet; park the target until it can.
        state_d = ST_IWAIT;
        if (!redir_pend_q) begin
          redir_pend_d = 1'b1;
          redir_pc_d   = x_target;
        end
      end
    end else if (load_use) begin
      dx_flush = 1'b1;
      dx_we    = 1'b1;
      xm_we    = 1'b1;
      mw_we    = 1'b1;
      state_d  = ST_RUN;
    end else if (i_stall) begin
      fd_flush = 1'b1;
      fd_we    = 1'b1;
      dx_we    = 1'b1;
      xm_we    = 1'b1;
      mw_we    = 1'b1;
      state_d  = ST_IWAIT;
    end else begin
      pc_we   = 1'b1;
      fd_we   = 1'b1;
      dx_we   = 1'b1;
      xm_we   = 1'b1;
      mw_we   = 1'b1;
      state_d = ST_RUN;
    end
  end

  // Count every cycle the PC holds while the core is still live.
  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (!rst && (state_q != ST_HALTED) && !pc_we) begin
      stall_cnt_d = stall_cnt_q + 1'b1;
    end
  end

  // State, pending-redirect and counter registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= ST_RUN;
      redir_pend_q <= 1'b0;
      redir_pc_q   <= '0;
      stall_cnt_q  <= '0;
    end else begin
      state_q      <= state_d;
      redir_pend_q <= redir_pend_d;
      redir_pc_q   <= redir_pc_d;
      stall_cnt_q  <= stall_cnt_d;
    end
  end

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Bench for pipe_hazard_ctrl: directed scenarios followed by random traffic,
// every cycle compared against a behavioural model of the sequencing rules.
module tb_pipe_hazard_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic [2:0]  fd_rs, fd_rt, dx_writeReg;
  logic        fd_uses_rs, fd_uses_rt, dx_memRead, dx_regWrite;
  logic        x_redirect;
  logic [15:0] x_target;
  logic        i_stall, d_stall, mw_halt;
  logic        pc_we, pc_sel_redirect, fd_we, dx_we, xm_we, mw_we;
  logic        fd_flush, dx_flush, halted;
  logic [15:0] redirect_pc;
  logic [15:0] stall_cnt;

  int checks = 0;
  int errors = 0;

  // Reference model state.
  bit          m_halted;
  bit          m_pend;
  logic [15:0] m_pend_pc;
  logic [15:0] m_cnt;

  always #5 clk = ~clk;

  pipe_hazard_ctrl #(.CNT_W(16)) dut (
    .clk             (clk),
    .rst             (rst),
    .fd_rs           (fd_rs),
    .fd_rt           (fd_rt),
    .fd_uses_rs      (fd_uses_rs),
    .fd_uses_rt      (fd_uses_rt),
    .dx_memRead      (dx_memRead),
    .dx_regWrite     (dx_regWrite),
    .dx_writeReg     (dx_writeReg),
    .x_redirect      (x_redirect),
    .x_target        (x_target),
    .i_stall         (i_stall),
    .d_stall         (d_stall),
    .mw_halt         (mw_halt),
    .pc_we           (pc_we),
    .pc_sel_redirect (pc_sel_redirect),
    .redirect_pc     (redirect_pc),
    .fd_we           (fd_we),
    .dx_we           (dx_we),
    .xm_we           (xm_we),
    .mw_we           (mw_we),
    .fd_flush        (fd_flush),
    .dx_flush        (dx_flush),
    .halted          (halted),
    .stall_cnt       (stall_cnt)
  );

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Does the FD instruction need a value the DX load has not produced yet?
  function automatic bit ref_load_use();
    logic [2:0] src [2];
    bit         used [2];
    src[0] = fd_rs;  used[0] = fd_uses_rs;
    src[1] = fd_rt;  used[1] = fd_uses_rt;
    if (!(dx_memRead && dx_regWrite)) return 0;
    for (int k = 0; k < 2; k++)
      if (used[k] && src[k] == dx_writeReg) return 1;
    return 0;
  endfunction

  // Expected {pc_we, pc_sel, fd_we, dx_we, xm_we, mw_we, fd_flush, dx_flush}.
  function automatic logic [7:0] ref_ctrl();
    if (rst || m_halted || mw_halt || d_stall) return 8'b0000_0000;
    if (x_redirect || m_pend)                  return {~i_stall, 7'b111_1111};
    if (ref_load_use())                        return 8'b0001_1101;
    if (i_stall)                               return 8'b0011_1110;
    return 8'b1011_1100;
  endfunction

  task automatic idle_inputs();
    rst = 0; fd_rs = 0; fd_rt = 0; fd_uses_rs = 0; fd_uses_rt = 0;
    dx_memRead = 0; dx_regWrite = 0; dx_writeReg = 0;
    x_redirect = 0; x_target = 0; i_stall = 0; d_stall = 0; mw_halt = 0;
  endtask

  // One clock: inputs must already be set; they are applied after the
  // falling edge, outputs checked, then the model advances on the rising edge.
  logic [7:0] nxt_in_buf;
  task automatic tick();
    logic [7:0]  exp_c;
    logic [7:0]  got_c;
    bit          n_halted, n_pend;
    logic [15:0] n_pc, n_cnt;
    @(negedge clk);
    #1;
    exp_c = ref_ctrl();
    got_c = {pc_we, pc_sel_redirect, fd_we, dx_we, xm_we, mw_we, fd_flush, dx_flush};
    check_val("ctrl", {24'd0, got_c}, {24'd0, exp_c});
    check_val("redirect_pc", {16'd0, redirect_pc}, {16'd0, (m_pend ? m_pend_pc : x_target)});
    check_val("halted", {31'd0, halted}, {31'd0, m_halted});
    check_val("stall_cnt", {16'd0, stall_cnt}, {16'd0, m_cnt});
    $display("cyc t=%0t rst=%0b xr=%0b is=%0b ds=%0b mh=%0b lu=%0b ctrl=%b pend=%0b cnt=%0d",
             $time, rst, x_redirect, i_stall, d_stall, mw_halt, ref_load_use(), got_c, m_pend, stall_cnt);
    n_halted = m_halted; n_pend = m_pend; n_pc = m_pend_pc; n_cnt = m_cnt;
    if (rst) begin
      n_halted = 0; n_pend = 0; n_pc = 0; n_cnt = 0;
    end else if (!m_halted) begin
      if (!exp_c[7]) n_cnt = m_cnt + 16'd1;
      if (mw_halt) n_halted = 1;
      else if (d_stall) begin
        if (x_redirect && !m_pend) begin n_pend = 1; n_pc = x_target; end
      end else if (x_redirect || m_pend) begin
        if (!i_stall) n_pend = 0;
        else if (!m_pend) begin n_pend = 1; n_pc = x_target; end
      end
    end
    @(posedge clk);
    m_halted = n_halted; m_pend = n_pend; m_pend_pc = n_pc; m_cnt = n_cnt;
    #1;
  endtask

  task automatic set_load_use_r3();
    dx_memRead = 1; dx_regWrite = 1; dx_writeReg = 3'd3;
    fd_rs = 3'd3; fd_uses_rs = 1;
  endtask

  task automatic do_reset();
    idle_inputs(); rst = 1;
    tick(); tick();
    rst = 0;
  endtask

  initial begin
    m_halted = 0; m_pend = 0; m_pend_pc = 0; m_cnt = 0;
    do_reset();

    // Load-use bubble, then free running.
    idle_inputs(); set_load_use_r3(); tick();
    check_val("lu_cnt", {16'd0, stall_cnt}, 32'd1);
    idle_inputs(); tick();

    // Taken branch with fetch ready.
    idle_inputs(); x_redirect = 1; x_target = 16'h0040; tick();
    idle_inputs(); tick();

    // Redirect while the fetch is stalled for three cycles.
    idle_inputs(); x_redirect = 1; x_target = 16'h0100; i_stall = 1; tick();
    x_redirect = 0; x_target = 16'h0bad; tick(); tick();
    i_stall = 0; tick();
    idle_inputs(); tick();

    // Data stall over a pending load-use hazard.
    do_reset();
    idle_inputs(); set_load_use_r3(); d_stall = 1;
    repeat (4) tick();
    d_stall = 0; tick();
    idle_inputs(); tick();
    check_val("ds_cnt", {16'd0, stall_cnt}, 32'd5);

    // Halt, then activity that must be ignored, then reset out of it.
    idle_inputs(); mw_halt = 1; tick();
    idle_inputs(); i_stall = 1; x_redirect = 1; x_target = 16'h0077; tick();
    i_stall = 0; tick();
    do_reset();
    idle_inputs(); tick();
    check_val("post_halt_cnt", {16'd0, stall_cnt}, 32'd0);

    // Reset in the middle of a parked redirect.
    idle_inputs(); x_redirect = 1; x_target = 16'h0200; i_stall = 1; tick();
    x_redirect = 0; tick();
    rst = 1; tick();
    idle_inputs(); tick();
    check_val("rst_psel", {31'd0, pc_sel_redirect}, 32'd0);

    // Random traffic with small register range so hazards are common.
    for (int n = 0; n < 1500; n++) begin
      rst         = ($urandom_range(0, 79) == 0);
      mw_halt     = ($urandom_range(0, 59) == 0);
      d_stall     = ($urandom_range(0, 4) == 0);
      i_stall     = ($urandom_range(0, 2) == 0);
      x_redirect  = ($urandom_range(0, 4) == 0);
      x_target    = 16'($urandom);
      dx_memRead  = $urandom_range(0, 1) == 1;
      dx_regWrite = $urandom_range(0, 3) != 0;
      dx_writeReg = 3'($urandom_range(0, 3));
      fd_rs       = 3'($urandom_range(0, 3));
      fd_rt       = 3'($urandom_range(0, 3));
      fd_uses_rs  = $urandom_range(0, 1) == 1;
      fd_uses_rt  = $urandom_range(0, 1) == 1;
      tick();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/pipe_hazard_ctrl.md
Name: pipe_hazard_ctrl

Overview:
- Central stall/flush sequencer for the five-stage pipeline.
- Produces write-enables and bubble-insert (flush) controls for the PC and the FD/DX/XM/MW pipe registers.
- Handles load-use hazards, taken branches/jumps, instruction- and data-memory wait states, and halt drain.
- Keeps a pending-redirect register so a branch resolved during a fetch stall is not lost, plus a stall-cycle counter.

Parameters:
- CNT_W, 16, width of stall-cycle counter.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- fd_rs  in  3  source reg 1 of instruction in FD
- fd_rt  in  3  source reg 2 of instruction in FD
- fd_uses_rs  in  1  FD instruction reads rs
- fd_uses_rt  in  1  FD instruction reads rt
- dx_memRead  in  1  instruction in DX is a load
- dx_regWrite  in  1  DX instruction writes a register
- dx_writeReg  in  3  DX destination register
- x_redirect  in  1  branch taken or jump resolved in X this cycle
- x_target  in  16  redirect target PC
- i_stall  in  1  instruction memory busy (fetch not complete)
- d_stall  in  1  data memory busy (M stage not complete)
- mw_halt  in  1  halt has reached MW
- pc_we  out  1  PC register update enable
- pc_sel_redirect  out  1  PC next-value mux selects redirect_pc
- redirect_pc  out  16  redirect target (live x_target or latched)
- fd_we, dx_we, xm_we, mw_we  out  1 each  pipe register enables
- fd_flush, dx_flush  out  1 each  load NOP/reset value into register
- halted  out  1  processor halted
- stall_cnt  out  CNT_W  cycles with pc_we=0 while not halted

Behaviour:
- State machine RUN, DWAIT, IWAIT, HALTED. Reset enters RUN.
  - Reset values: redir_pend=0, redir_pc=0, stall_cnt=0, halted=0.
  - During rst=1 all enables=0 and flushes=0.
- Per-cycle priority, highest first:
  1. HALTED: all enables 0, flushes 0, halted=1. Leave only via rst.
  2. mw_halt=1: next state HALTED. This cycle all enables 0.
  3. d_stall=1 (DWAIT): freeze everything; all we=0, flushes=0.
     - An x_redirect seen this cycle is latched into redir_pend/redir_pc. The X instruction stays frozen and re-asserts x_redirect later, so latching is idempotent.
  4. x_redirect=1 or redir_pend=1:
     - pc_sel_redirect=1; redirect_pc = redir_pend ? redir_pc : x_target.
     - fd_flush=1 and dx_flush=1 with fd_we=dx_we=1; xm_we=mw_we=1.
     - If i_stall=0: pc_we=1 and redir_pend clears next cycle.
     - If i_stall=1: pc_we=0, redir_pend set and redir_pc latched (if not already pending), state IWAIT.
  5. Load-use hazard: dx_memRead & dx_regWrite & ((fd_uses_rs & fd_rs==dx_writeReg) | (fd_uses_rt & fd_rt==dx_writeReg)).
     - pc_we=0, fd_we=0, dx_flush=1, dx_we=1, xm_we=mw_we=1.
     - r0 is a real register; no zero-register exclusion.
  6. i_stall=1 (IWAIT): pc_we=0, fd_flush=1, fd_we=1, downstream enables 1.
  7. Otherwise: all enables 1, flushes 0.
- Returning from IWAIT to RUN happens on the first cycle with i_stall=0. If redir_pend is set, that cycle's fetched word is discarded (fd_flush=1) and the PC loads redir_pc.
- A flush takes effect together with its we on the same clock edge; flush overrides the D input.
- stall_cnt increments (wraps) every cycle pc_we=0 and state is not HALTED and rst=0.
- All outputs except redirect_pc and stall_cnt are combinational from state + inputs. No registered latency beyond the redir_pend register.

Decomposition:
- Shared package: state encoding constants (RUN=2'b00, DWAIT=2'b01, IWAIT=2'b10, HALTED=2'b11) and the NOP instruction constant used by the pipe flushes.
- One natural sub-module: load_use_detect (pure compare logic).
- Registers use the existing dff cell with synchronous reset.

Test Plan:
- Load-use: DX=load r3, FD reads rs=r3 -> one cycle with pc_we=0, fd_we=0, dx_flush=1; next cycle all enables 1; stall_cnt=1.
- Branch redirect: x_redirect=1, x_target=0x0040, i_stall=0 -> pc_we=1, pc_sel_redirect=1, redirect_pc=0x0040, fd_flush=dx_flush=1 for exactly one cycle.
- Redirect during fetch stall: x_redirect with target 0x0100 while i_stall=1 for 3 cycles -> redir_pend holds. On i_stall falling: pc_we=1, redirect_pc=0x0100, fd_flush=1; redir_pend=0 after.
- Data stall: d_stall=1 for 4 cycles with a load-use hazard present -> all enables 0 for 4 cycles, then the load-use bubble; stall_cnt=5.
- Halt: mw_halt=1 -> halted=1 next cycle and all enables stay 0 despite i_stall/x_redirect activity; rst=1 returns to RUN with stall_cnt=0.
- Reset mid-IWAIT with redir_pend=1 -> after reset, redir_pend=0, pc_sel_redirect=0, state RUN.
